// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns stage for the decryption datapath.
// A 128-bit state is accepted over valid/ready and COLS_PER_CYCLE columns are
// transformed in place per BUSY cycle. The result is held until it is accepted.
module inv_mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  // Column group advance per cycle and the starting column of the final group.
  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
      $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  state_t       r_state;
  logic [1:0]   r_col_cnt;
  logic [127:0] r_work;
  logic         r_out_valid;

  logic [31:0]  w_cols      [4];
  logic [31:0]  w_col_out   [4];
  logic [31:0]  w_next_cols [4];
  logic [127:0] w_work_next;

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
  endfunction

  // InvMixColumns of one column; byte 0 lives in the MSB.
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a   [4];
    logic [7:0] m9  [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [7:0] x1, x2, x3;
    for (int i = 0; i < 4; i++) begin
      a[i]   = c[31-8*i -: 8];
      x1     = xtime(a[i]);
      x2     = xtime(x1);
      x3     = xtime(x2);
      m9[i]  = x3 ^ a[i];
      m11[i] = x3 ^ x1 ^ a[i];
      m13[i] = x3 ^ x2 ^ a[i];
      m14[i] = x3 ^ x2 ^ x1;
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction

  // Only COLS_PER_CYCLE transform units exist; unit g works on column col_cnt+g.
  // Each column then picks its transformed value when it falls in the current
  // group, otherwise it keeps its present contents.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col
      logic [1:0] w_ofs;

      assign w_cols[gi] = r_work[127-32*gi -: 32];

      if (gi < COLS_PER_CYCLE) begin : g_unit
        logic [1:0] w_src_idx;
        assign w_src_idx     = r_col_cnt + 2'(gi);
        assign w_col_out[gi] = inv_col(w_cols[w_src_idx]);
      end else begin : g_no_unit
        assign w_col_out[gi] = '0;
      end

      assign w_ofs            = 2'(gi) - r_col_cnt;
      assign w_next_cols[gi]  = ({1'b0, w_ofs} < 3'(COLS_PER_CYCLE)) ? w_col_out[w_ofs]
                                                                     : w_cols[gi];
      assign w_work_next[127-32*gi -: 32] = w_next_cols[gi];
    end
  endgenerate

  // Control FSM with the work register and registered output valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_col_cnt   <= 2'd0;
      r_work      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_work    <= in_data;
            r_col_cnt <= 2'd0;
            r_state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_work <= w_work_next;
          if (r_col_cnt == LAST_COL) begin
            r_col_cnt   <= 2'd0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_col_cnt <= r_col_cnt + STEP;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = r_out_valid;
  assign out_data  = r_work;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Scoreboard bench for inv_mix_columns_seq with one instance per legal
// COLS_PER_CYCLE (index 0: C=1, 1: C=2, 2: C=4).
module tb_inv_mix_columns_seq;

  localparam logic [127:0] V2_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2_EXP = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V3_IN  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] V3_EXP = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;

  typedef struct {
    logic [127:0] data;
    int           acc;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_data   [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_data  [3];
  logic         busy      [3];

  exp_t sb_q [3][$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   prev_v [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      inv_mix_columns_seq #(.COLS_PER_CYCLE(1 << gi)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[gi]),
        .in_ready  (in_ready[gi]),
        .in_data   (in_data[gi]),
        .out_valid (out_valid[gi]),
        .out_ready (out_ready[gi]),
        .out_data  (out_data[gi]),
        .busy      (busy[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: latency check when out_valid rises, data check on each handshake.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (out_valid[i] === 1'b1 && !prev_v[i]) begin
        if (sb_q[i].size() == 0)
          chk($sformatf("unexpected_valid_c%0d", 1 << i), 128'd1, 128'd0);
        else
          chk($sformatf("latency_c%0d", 1 << i), 128'(cyc - sb_q[i][0].acc), 128'(4 >> i));
      end
      if (out_valid[i] === 1'b1 && out_ready[i] === 1'b1 && sb_q[i].size() != 0) begin
        e = sb_q[i].pop_front();
        chk($sformatf("data_c%0d", 1 << i), out_data[i], e.data);
        $display("[TB] c%0d out %h", 1 << i, out_data[i]);
      end
      prev_v[i] = (out_valid[i] === 1'b1);
    end
  end

  task automatic send(input int i, input logic [127:0] d, input logic [127:0] e,
                      input bit push, output int acc);
    int n;
    n = 0;
    in_data[i]  = d;
    in_valid[i] = 1'b1;
    while (in_ready[i] !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready[i] !== 1'b1) begin
      chk("accept_timeout", {127'd0, in_ready[i]}, 128'd1);
      in_valid[i] = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
    acc = cyc;
    if (push) sb_q[i].push_back('{e, acc});
    $display("[TB] c%0d in  %h at cycle %0d", 1 << i, d, acc);
  endtask

  task automatic wait_drain(input int i);
    int n;
    n = 0;
    while (sb_q[i].size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk($sformatf("drain_c%0d", 1 << i), 128'(sb_q[i].size()), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_a, acc_b, n;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      out_ready[i] = 1'b1;
      prev_v[i]    = 1'b0;
    end

    // Asynchronous reset asserted between edges takes effect immediately.
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_out_valid", {127'd0, out_valid[i]}, 128'd0);
      chk("rst_out_data", out_data[i], 128'd0);
      chk("rst_busy", {127'd0, busy[i]}, 128'd0);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) chk("rst_in_ready", {127'd0, in_ready[i]}, 128'd1);

    // Known-answer state, C=1.
    send(0, V2_IN, V2_EXP, 1'b1, acc_a);
    wait_drain(0);

    // Second vector on every column width.
    for (int i = 0; i < 3; i++) begin
      send(i, V3_IN, V3_EXP, 1'b1, acc_a);
      wait_drain(i);
    end

    // Backpressure: result held in DONE, extra input ignored.
    out_ready[0] = 1'b0;
    send(0, V2_IN, V2_EXP, 1'b1, acc_a);
    n = 0;
    while (out_valid[0] !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_valid_seen", {127'd0, out_valid[0]}, 128'd1);
    in_data[0]  = V3_IN;
    in_valid[0] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_data_stable", out_data[0], V2_EXP);
      chk("bp_in_ready", {127'd0, in_ready[0]}, 128'd0);
      chk("bp_out_valid", {127'd0, out_valid[0]}, 128'd1);
    end
    @(posedge clk); #1;
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_in_ready", {127'd0, in_ready[0]}, 128'd1);
    chk("bp_idle_out_valid", {127'd0, out_valid[0]}, 128'd0);
    chk("bp_idle_busy", {127'd0, busy[0]}, 128'd0);
    repeat (8) @(posedge clk);
    #1;

    // Back-to-back with the consumer always ready.
    send(0, V2_IN, V2_EXP, 1'b1, acc_a);
    send(0, V3_IN, V3_EXP, 1'b1, acc_b);
    chk("b2b_spacing", 128'(acc_b - acc_a), 128'd6);
    wait_drain(0);

    // Reset while BUSY at col_cnt=2 discards the state.
    send(0, V3_IN, V3_EXP, 1'b0, acc_a);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", {127'd0, out_valid[0]}, 128'd0);
    chk("midrst_out_data", out_data[0], 128'd0);
    chk("midrst_busy", {127'd0, busy[0]}, 128'd0);
    #1 rst = 1'b0;
    #1;
    chk("midrst_in_ready", {127'd0, in_ready[0]}, 128'd1);
    repeat (8) @(posedge clk);
    #1;
    send(0, V2_IN, V2_EXP, 1'b1, acc_a);
    wait_drain(0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
